hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and multi-cycle scheduling controller for the five-stage core. It generates stall, flush and forwarding selects for the F/D/E stages, including the ID-stage branch comparator forwarding (`forwardAD`/`forwardBD`). It also sequences the shared multi-cycle multiply/divide unit: it holds the front end while the unit is busy and pulses the HI/LO write when a result is ready. A saturating stall-cycle counter is provided for performance debug.

## Interface
- `MUL_CYCLES`, 4: execution cycles of a multiply (≥1).
- `DIV_CYCLES`, 33: execution cycles of a divide (≥1).
- `CNT_WIDTH`, 6: width of the mul/div down-counter; must hold `max(MUL_CYCLES,DIV_CYCLES)-1`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rsD`, `rtD`  in  5 each  source registers of the instruction in D.
- `branchD`  in  1  D holds a branch that compares in ID.
- `mdReqD`  in  1  D holds a mul/div instruction.
- `hiloReadD`  in  1  D holds an mfhi/mflo instruction.
- `rsE`, `rtE`, `writeRegE`  in  5 each  E-stage source and destination registers.
- `Regfile_weE`, `memToRegE`  in  1 each  E writes the register file / E is a load.
- `writeRegM`, `Regfile_weM`, `memToRegM`  in  5/1/1  M-stage destination, write enable, load.
- `writeRegW`, `Regfile_weW`  in  5/1  W-stage destination and write enable.
- `mdStartE`  in  1  one-cycle start pulse from E.
- `mdIsDivE`  in  1  qualifies `mdStartE`: 1 = divide, 0 = multiply.
- `clrStats`  in  1  synchronous clear of `stallCount` and `mdOverrun`.
- `stallF`, `stallD`, `flushE`  out  1 each  pipeline control.
- `forwardAD`, `forwardBD`  out  1 each  select `aluOutM` into the ID branch compare.
- `forwardAE`, `forwardBE`  out  2 each  E-operand select: 00 regfile, 01 W result, 10 M result.
- `mdBusy`  out  1  mul/div unit executing.
- `mdDone`  out  1  registered one-cycle HI/LO write strobe.
- `mdOverrun`  out  1  sticky: start received while not IDLE.
- `stallCount`  out  16  saturating count of cycles with `stallD`=1.

## Operation
- Register matching: a source register of 0 never matches anything.
- `forwardAE`: 10 if `rsE`==`writeRegM`&`Regfile_weM`; else 01 if `rsE`==`writeRegW`&`Regfile_weW`; else 00. M takes priority over W. `forwardBE` is the same using `rtE`.
- `forwardAD`: `rsD`==`writeRegM`&`Regfile_weM`. `forwardBD` is the same using `rtD`.
- lwStall: `memToRegE` & (`writeRegE`==`rsD` | `writeRegE`==`rtD`).
- brStall: `branchD` & ((`Regfile_weE` & `writeRegE`∈{`rsD`,`rtD`}) | (`memToRegM` & `writeRegM`∈{`rsD`,`rtD`})).
- mdStall: (`mdReqD`|`hiloReadD`) & (state≠IDLE | `mdStartE`).
- `stallF`=`stallD`=`flushE`= lwStall|brStall|mdStall.
- FSM states:
  - IDLE:
    - on `mdStartE`, load counter with `DIV_CYCLES-1` if `mdIsDivE`, else `MUL_CYCLES-1`;
    - go to BUSY.
  - BUSY:
    - counter≠0: decrement;
    - counter==0: go to DONE.
  - DONE: go to IDLE unconditionally.
- `mdBusy` = (state==BUSY); `mdDone` = (state==DONE).
- `mdStartE` in BUSY or DONE is ignored: no reload, and `mdOverrun` sets.
- `stallCount`: increments each cycle `stallD`=1 and saturates at 0xFFFF. `clrStats` clears it and `mdOverrun`; `clrStats` wins over an increment in the same cycle.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE, counter=0, `stallCount`=0, `mdOverrun`=0, `mdBusy`=`mdDone`=0.
  - All stall, flush and forward outputs are forced to 0 while `rst`=0.
- Reset asserted mid-operation aborts the operation: no `mdDone` is produced.
- Stall, flush and forward outputs are combinational from the current-cycle inputs and state, with zero latency.
- Mul/div latency: `mdStartE` sampled at edge 0.
  - `mdBusy`=1 for exactly N cycles following edge 0.
  - `mdDone`=1 for the single cycle following edge N.
  - N = `MUL_CYCLES` or `DIV_CYCLES`.
- mdStall is active in the start cycle, through all BUSY cycles and through DONE, so a dependent mfhi leaves D in the first IDLE cycle.
- Simultaneous stall sources are ORed. Forwarding outputs are not masked by a stall.

## Test plan
- Load-use:
  - Stimulus: E=`lw $8` (`memToRegE`=1, `writeRegE`=8), D `rsD`=8.
  - Response: `stallF`=`stallD`=`flushE`=1 for 1 cycle; `stallCount`=1.
- Double-hit forwarding:
  - Stimulus: `writeRegM`=`writeRegW`=5, both write enables=1, `rsE`=5, `rtE`=0.
  - Response: `forwardAE`=10, `forwardBE`=00.
- Branch in ID:
  - Stimulus: `branchD`, `rsD`=3, E writes $3.
  - Response: brStall for 1 cycle.
  - Next cycle: `writeRegM`=3, non-load.
  - Response: no stall, `forwardAD`=1.
- Divide:
  - Stimulus: `mdStartE`, `mdIsDivE`=1, `DIV_CYCLES`=33; `hiloReadD` held.
  - Response: `mdBusy` high 33 cycles; `mdDone` 1 cycle; stalls 35 cycles total; release in the first IDLE cycle.
- Overrun and reset:
  - Stimulus: second `mdStartE` during BUSY.
  - Response: `mdOverrun`=1, completion timing unchanged.
  - Stimulus: `rst` low mid-BUSY.
  - Response: all outputs 0, IDLE, no `mdDone`.
- Counter saturation:
  - Stimulus: force 70000 stall cycles.
  - Response: `stallCount`=0xFFFF.
  - Stimulus: `clrStats` during a stall cycle.
  - Response: `stallCount`=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline-side signal bundle for the hazard / mul-div
//                scheduling controller. The master is the pipeline, which
//                drives the stage information. The slave is hazard_ctrl,
//                which returns the stall, flush and forward controls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  // D stage
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic        branchD;
  logic        mdReqD;
  logic        hiloReadD;
  // E stage
  logic [4:0]  rsE;
  logic [4:0]  rtE;
  logic [4:0]  writeRegE;
  logic        Regfile_weE;
  logic        memToRegE;
  logic        mdStartE;
  logic        mdIsDivE;
  // M stage
  logic [4:0]  writeRegM;
  logic        Regfile_weM;
  logic        memToRegM;
  // W stage
  logic [4:0]  writeRegW;
  logic        Regfile_weW;
  // debug
  logic        clrStats;
  // controller outputs
  logic        stallF;
  logic        stallD;
  logic        flushE;
  logic        forwardAD;
  logic        forwardBD;
  logic [1:0]  forwardAE;
  logic [1:0]  forwardBE;
  logic        mdBusy;
  logic        mdDone;
  logic        mdOverrun;
  logic [15:0] stallCount;

  modport master (
    output rsD, rtD, branchD, mdReqD, hiloReadD,
    output rsE, rtE, writeRegE, Regfile_weE, memToRegE, mdStartE, mdIsDivE,
    output writeRegM, Regfile_weM, memToRegM,
    output writeRegW, Regfile_weW,
    output clrStats,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
    input  mdBusy, mdDone, mdOverrun, stallCount
  );

  modport slave (
    input  rsD, rtD, branchD, mdReqD, hiloReadD,
    input  rsE, rtE, writeRegE, Regfile_weE, memToRegE, mdStartE, mdIsDivE,
    input  writeRegM, Regfile_weM, memToRegM,
    input  writeRegW, Regfile_weW,
    input  clrStats,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
    output mdBusy, mdDone, mdOverrun, stallCount
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall / flush / forward generation for the F/D/E stages,
//                including ID-stage branch-compare forwarding. It also
//                sequences the shared multi-cycle mul/div unit and keeps a
//                saturating stall-cycle counter for performance debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst,   // asynchronous, active-low
  hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [15:0]          CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  md_state_e            state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overrun_q, overrun_d;
  logic [15:0]          stall_cnt_q, stall_cnt_d;

  // Register $0 is hard-wired zero, so it can never carry a hazard.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  logic       rsD_hitE, rtD_hitE, rsD_hitM, rtD_hitM;
  logic       lw_stall, br_stall, md_stall, stall;
  logic [1:0] fwd_ae, fwd_be;

  assign rsD_hitE = reg_match(hz.rsD, hz.writeRegE);
  assign rtD_hitE = reg_match(hz.rtD, hz.writeRegE);
  assign rsD_hitM = reg_match(hz.rsD, hz.writeRegM);
  assign rtD_hitM = reg_match(hz.rtD, hz.writeRegM);

  assign lw_stall = hz.memToRegE & (rsD_hitE | rtD_hitE);
  assign br_stall = hz.branchD &
                    ((hz.Regfile_weE & (rsD_hitE | rtD_hitE)) |
                     (hz.memToRegM   & (rsD_hitM | rtD_hitM)));
  // A start in the current cycle already blocks a dependent mul/div or mfhi.
  assign md_stall = (hz.mdReqD | hz.hiloReadD) & ((state_q != S_IDLE) | hz.mdStartE);
  assign stall    = lw_stall | br_stall | md_stall;

  // E-operand forwarding: the younger M result wins over W.
  always_comb begin
    fwd_ae = 2'b00;
    fwd_be = 2'b00;
    if (reg_match(hz.rsE, hz.writeRegM) && hz.Regfile_weM)      fwd_ae = 2'b10;
    else if (reg_match(hz.rsE, hz.writeRegW) && hz.Regfile_weW) fwd_ae = 2'b01;
    if (reg_match(hz.rtE, hz.writeRegM) && hz.Regfile_weM)      fwd_be = 2'b10;
    else if (reg_match(hz.rtE, hz.writeRegW) && hz.Regfile_weW) fwd_be = 2'b01;
  end

  // Combinational controls are held low for the whole time reset is asserted.
  assign hz.stallF    = rst & stall;
  assign hz.stallD    = rst & stall;
  assign hz.flushE    = rst & stall;
  assign hz.forwardAD = rst & rsD_hitM & hz.Regfile_weM;
  assign hz.forwardBD = rst & rtD_hitM & hz.Regfile_weM;
  assign hz.forwardAE = rst ? fwd_ae : 2'b00;
  assign hz.forwardBE = rst ? fwd_be : 2'b00;

  assign hz.mdBusy     = busy_q;
  assign hz.mdDone     = done_q;
  assign hz.mdOverrun  = overrun_q;
  assign hz.stallCount = stall_cnt_q;

  // Mul/div sequencer: IDLE -> BUSY (N cycles) -> DONE (1 cycle) -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hz.mdStartE) begin
            cnt_q   <= hz.mdIsDivE ? DIV_LOAD : MUL_LOAD;
            state_q <= S_BUSY;
            busy_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Debug statistics: clear has priority over both overrun set and increment.
  always_comb begin
    overrun_d   = overrun_q;
    stall_cnt_d = stall_cnt_q;
    if (hz.clrStats) begin
      overrun_d   = 1'b0;
      stall_cnt_d = 16'd0;
    end else begin
      if (hz.mdStartE && (state_q != S_IDLE)) overrun_d = 1'b1;
      if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      overrun_q   <= overrun_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a timeline-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_WIDTH (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the mul/div op is tracked as a start cycle and length.
  int cyc      = 0;
  int md_start = -1;
  int md_n     = 0;
  bit m_ovr    = 1'b0;
  int m_cnt    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit hit(input logic [4:0] s, input logic [4:0] d);
    return (s != 5'd0) && (s == d);
  endfunction

  function automatic int phase();
    return (md_start < 0) ? -1 : (cyc - md_start);
  endfunction

  function automatic bit m_busy();
    int k = phase();
    return (k >= 1) && (k <= md_n);
  endfunction

  function automatic bit m_done();
    return phase() == md_n + 1;
  endfunction

  function automatic bit m_stall();
    bit lw, br, md;
    lw = hz.memToRegE && (hit(hz.rsD, hz.writeRegE) || hit(hz.rtD, hz.writeRegE));
    br = hz.branchD &&
         ((hz.Regfile_weE && (hit(hz.rsD, hz.writeRegE) || hit(hz.rtD, hz.writeRegE))) ||
          (hz.memToRegM   && (hit(hz.rsD, hz.writeRegM) || hit(hz.rtD, hz.writeRegM))));
    md = (hz.mdReqD || hz.hiloReadD) && (m_busy() || m_done() || hz.mdStartE);
    return lw || br || md;
  endfunction

  function automatic int fwd_e(input logic [4:0] s);
    if (hit(s, hz.writeRegM) && hz.Regfile_weM) return 2;
    if (hit(s, hz.writeRegW) && hz.Regfile_weW) return 1;
    return 0;
  endfunction

  task automatic compare_model();
    bit r = rst;
    int s = r ? int'(m_stall()) : 0;
    chk("stallF", int'(hz.stallF), s);
    chk("stallD", int'(hz.stallD), s);
    chk("flushE", int'(hz.flushE), s);
    chk("forwardAD", int'(hz.forwardAD), r ? int'(hit(hz.rsD, hz.writeRegM) && hz.Regfile_weM) : 0);
    chk("forwardBD", int'(hz.forwardBD), r ? int'(hit(hz.rtD, hz.writeRegM) && hz.Regfile_weM) : 0);
    chk("forwardAE", int'(hz.forwardAE), r ? fwd_e(hz.rsE) : 0);
    chk("forwardBE", int'(hz.forwardBE), r ? fwd_e(hz.rtE) : 0);
    chk("mdBusy", int'(hz.mdBusy), r ? int'(m_busy()) : 0);
    chk("mdDone", int'(hz.mdDone), r ? int'(m_done()) : 0);
    chk("mdOverrun", int'(hz.mdOverrun), r ? int'(m_ovr) : 0);
    chk("stallCount", int'(hz.stallCount), r ? m_cnt : 0);
  endtask

  task automatic update_model();
    if (!rst) begin
      md_start = -1;
      m_ovr    = 1'b0;
      m_cnt    = 0;
    end else begin
      bit active = m_busy() || m_done();
      bit s      = m_stall();
      if (hz.mdStartE) begin
        if (!active) begin
          md_start = cyc;
          md_n     = hz.mdIsDivE ? DIV_N : MUL_N;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (hz.clrStats) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end else if (s && m_cnt < 65535) begin
        m_cnt++;
      end
    end
    cyc++;
  endtask

  // One clock cycle: inputs already applied at posedge+1; check, then advance.
  task automatic cycle();
    #2;
    compare_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    hz.rsD = 0; hz.rtD = 0; hz.branchD = 0; hz.mdReqD = 0; hz.hiloReadD = 0;
    hz.rsE = 0; hz.rtE = 0; hz.writeRegE = 0; hz.Regfile_weE = 0; hz.memToRegE = 0;
    hz.mdStartE = 0; hz.mdIsDivE = 0;
    hz.writeRegM = 0; hz.Regfile_weM = 0; hz.memToRegM = 0;
    hz.writeRegW = 0; hz.Regfile_weW = 0; hz.clrStats = 0;
  endtask

  task automatic rand_inputs();
    hz.rsD = 5'($urandom_range(0, 7));       hz.rtD = 5'($urandom_range(0, 7));
    hz.rsE = 5'($urandom_range(0, 7));       hz.rtE = 5'($urandom_range(0, 7));
    hz.writeRegE = 5'($urandom_range(0, 7)); hz.writeRegM = 5'($urandom_range(0, 7));
    hz.writeRegW = 5'($urandom_range(0, 7));
    hz.branchD     = ($urandom_range(0, 2) == 0);
    hz.mdReqD      = ($urandom_range(0, 3) == 0);
    hz.hiloReadD   = ($urandom_range(0, 3) == 0);
    hz.Regfile_weE = $urandom_range(0, 1);
    hz.memToRegE   = ($urandom_range(0, 2) == 0);
    hz.Regfile_weM = $urandom_range(0, 1);
    hz.memToRegM   = ($urandom_range(0, 2) == 0);
    hz.Regfile_weW = $urandom_range(0, 1);
    hz.mdStartE    = ($urandom_range(0, 11) == 0);
    hz.mdIsDivE    = ($urandom_range(0, 2) == 0);
    hz.clrStats    = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    int stalls, busyc, donec, first_free;
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset state
    cycle(); cycle();
    #1; chk("rst_stallCount", int'(hz.stallCount), 0);
    chk("rst_mdBusy", int'(hz.mdBusy), 0);
    rst = 1'b1;
    cycle(); cycle();

    // Load-use
    hz.memToRegE = 1; hz.Regfile_weE = 1; hz.writeRegE = 8; hz.rsD = 8;
    #1; chk("lu_stallF", int'(hz.stallF), 1); chk("lu_flushE", int'(hz.flushE), 1);
    cycle();
    clear_inputs();
    #1; chk("lu_release", int'(hz.stallD), 0); chk("lu_count", int'(hz.stallCount), 1);
    cycle();

    // Double-hit forwarding
    hz.writeRegM = 5; hz.writeRegW = 5; hz.Regfile_weM = 1; hz.Regfile_weW = 1;
    hz.rsE = 5; hz.rtE = 0;
    #1; chk("dh_forwardAE", int'(hz.forwardAE), 2); chk("dh_forwardBE", int'(hz.forwardBE), 0);
    cycle();
    clear_inputs();

    // Branch in ID
    hz.branchD = 1; hz.rsD = 3; hz.Regfile_weE = 1; hz.writeRegE = 3;
    #1; chk("br_stall", int'(hz.stallD), 1);
    cycle();
    hz.Regfile_weE = 0; hz.writeRegE = 0; hz.writeRegM = 3; hz.Regfile_weM = 1;
    #1; chk("br_release", int'(hz.stallD), 0); chk("br_forwardAD", int'(hz.forwardAD), 1);
    cycle();
    clear_inputs();

    // Divide with dependent mfhi held in D
    hz.hiloReadD = 1; hz.mdStartE = 1; hz.mdIsDivE = 1;
    stalls = 0; busyc = 0; donec = 0; first_free = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      stalls += int'(hz.stallD); busyc += int'(hz.mdBusy); donec += int'(hz.mdDone);
      if (!hz.stallD && first_free < 0) first_free = i;
      cycle();
      hz.mdStartE = 0; hz.mdIsDivE = 0;
    end
    chk("div_stalls", stalls, 35); chk("div_busy", busyc, 33);
    chk("div_done", donec, 1);     chk("div_release", first_free, 35);
    clear_inputs();

    // Overrun: second start during a multiply is ignored
    hz.mdStartE = 1;
    busyc = 0; donec = 0;
    for (int i = 0; i < 10; i++) begin
      #1; busyc += int'(hz.mdBusy); donec += int'(hz.mdDone);
      cycle();
      hz.mdStartE = (i == 1);
    end
    chk("ovr_busy", busyc, MUL_N); chk("ovr_done", donec, 1);
    #1; chk("ovr_flag", int'(hz.mdOverrun), 1);
    hz.clrStats = 1; cycle(); hz.clrStats = 0;
    #1; chk("ovr_clear", int'(hz.mdOverrun), 0);
    cycle();

    // Reset mid-BUSY aborts the operation
    hz.mdStartE = 1; hz.mdIsDivE = 1;
    cycle();
    clear_inputs();
    for (int i = 0; i < 5; i++) cycle();
    hz.hiloReadD = 1; hz.memToRegE = 1; hz.writeRegE = 8; hz.rsD = 8;
    rst = 1'b0;
    #1; chk("arst_busy", int'(hz.mdBusy), 0); chk("arst_stall", int'(hz.stallD), 0);
    cycle(); cycle();
    rst = 1'b1;
    clear_inputs();
    donec = 0;
    for (int i = 0; i < 40; i++) begin
      #1; donec += int'(hz.mdDone);
      cycle();
    end
    chk("arst_no_done", donec, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 40; i++) cycle();

    // Counter saturation, then clear during a stall cycle
    hz.memToRegE = 1; hz.writeRegE = 9; hz.rtD = 9;
    for (int i = 0; i < 70000; i++) cycle();
    #1; chk("sat_count", int'(hz.stallCount), 16'hFFFF);
    hz.clrStats = 1;
    cycle();
    hz.clrStats = 0;
    #1; chk("clr_count", int'(hz.stallCount), 0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
